// File: rtl/dit_lockstep_monitor_pkg.sv
// Shared types and helpers for the data-independent-timing lockstep monitor.
// Holds the monitor state encoding, the skew limit and a saturating increment.
package dit_lockstep_monitor_pkg;

  typedef enum logic [2:0] {
    MON_IDLE   = 3'd0,
    MON_FILL   = 3'd1,
    MON_CHECK  = 3'd2,
    MON_FAIL   = 3'd3,
    MON_CONSTR = 3'd4
  } mon_state_e;

  localparam int MAX_SKEW = 7;
  localparam int FILL_W   = 3;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/dit_lockstep_monitor_if.sv
// Bundle of the two core copies' control signals plus the monitor results.
// The master side drives the copies' signals; the slave side is the monitor.
interface dit_lockstep_monitor_if #(
  parameter int CTRL_W  = 64,
  parameter int NUM_GRP = 8,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 2,
  parameter int CNT_W   = 32
);

  logic               enable;
  logic               clear;
  logic [IN_W-1:0]    ctrl_in_a;
  logic [IN_W-1:0]    ctrl_in_b;
  logic [CTRL_W-1:0]  state_a;
  logic [CTRL_W-1:0]  state_b;
  logic [OUT_W-1:0]   out_a;
  logic [OUT_W-1:0]   out_b;

  logic               violation;
  logic               assume_fail;
  logic [NUM_GRP:0]   fail_grp;
  logic [CNT_W-1:0]   fail_cycle;
  logic [CNT_W-1:0]   checked_cnt;
  logic [2:0]         mon_state;

  modport master (
    output enable, clear, ctrl_in_a, ctrl_in_b, state_a, state_b, out_a, out_b,
    input  violation, assume_fail, fail_grp, fail_cycle, checked_cnt, mon_state
  );

  modport slave (
    input  enable, clear, ctrl_in_a, ctrl_in_b, state_a, state_b, out_a, out_b,
    output violation, assume_fail, fail_grp, fail_cycle, checked_cnt, mon_state
  );

endinterface

// File: rtl/dit_lockstep_monitor_skew_line.sv
// DEPTH-deep shift register that delays copy A so it lines up with the lagging copy B.
// A depth of zero degenerates to a plain wire.
module dit_lockstep_monitor_skew_line
  import dit_lockstep_monitor_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int D = (DEPTH > MAX_SKEW) ? MAX_SKEW : DEPTH;

  generate
    if (D == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;
      assign dout = din;
    end else begin : g_pipe
      logic [W-1:0] stage_q [D];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < D; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= din;
          for (int i = 1; i < D; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign dout = stage_q[D-1];
    end
  endgenerate

endmodule

// File: rtl/dit_lockstep_monitor.sv
// Run-time DIT lockstep monitor: compares skew-aligned control state/outputs of two core
// copies every cycle and latches the first divergence or input-constraint breach.
module dit_lockstep_monitor
  import dit_lockstep_monitor_pkg::*;
#(
  parameter int CTRL_W  = 64,
  parameter int NUM_GRP = 8,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 2,
  parameter int SKEW    = 0,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dit_lockstep_monitor_if.slave mon
);

  localparam int GW     = CTRL_W / NUM_GRP;
  localparam int DLY_W  = IN_W + CTRL_W + OUT_W;
  localparam int SKEW_C = (SKEW > MAX_SKEW) ? MAX_SKEW : SKEW;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((SKEW_C > 0) ? SKEW_C - 1 : 0);

  logic [DLY_W-1:0]  a_now;
  logic [DLY_W-1:0]  a_dly;
  logic [IN_W-1:0]   in_a_dly;
  logic [CTRL_W-1:0] state_a_dly;
  logic [OUT_W-1:0]  out_a_dly;

  assign a_now = {mon.ctrl_in_a, mon.state_a, mon.out_a};

  dit_lockstep_monitor_skew_line #(
    .W     (DLY_W),
    .DEPTH (SKEW_C)
  ) u_skew_line (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (a_now),
    .dout    (a_dly)
  );

  assign {in_a_dly, state_a_dly, out_a_dly} = a_dly;

  // One mismatch bit per control register bank, plus the output mismatch on top.
  logic [NUM_GRP:0] mis_mask;
  logic             in_mis;

  generate
    for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
      assign mis_mask[gi] = |(state_a_dly[gi*GW +: GW] ^ mon.state_b[gi*GW +: GW]);
    end
  endgenerate

  assign mis_mask[NUM_GRP] = |(out_a_dly ^ mon.out_b);
  assign in_mis            = |(in_a_dly ^ mon.ctrl_in_b);

  mon_state_e         state_q;
  logic [FILL_W-1:0]  fill_q;
  logic               violation_q;
  logic               assume_q;
  logic [NUM_GRP:0]   fail_grp_q;
  logic [CNT_W-1:0]   fail_cycle_q;
  logic [CNT_W-1:0]   checked_q;
  logic [CNT_W-1:0]   cycle_q;
  logic [CNT_W-1:0]   checked_d;
  logic [CNT_W-1:0]   cycle_d;

  always_comb begin
    cycle_d   = CNT_W'(sat_inc(64'(cycle_q), CNT_W));
    checked_d = CNT_W'(sat_inc(64'(checked_q), CNT_W));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= MON_IDLE;
      fill_q       <= '0;
      violation_q  <= 1'b0;
      assume_q     <= 1'b0;
      fail_grp_q   <= '0;
      fail_cycle_q <= '0;
      checked_q    <= '0;
      cycle_q      <= '0;
    end else begin
      cycle_q <= cycle_d;
      unique case (state_q)
        MON_IDLE: begin
          if (mon.enable) begin
            fill_q  <= '0;
            state_q <= (SKEW_C == 0) ? MON_CHECK : MON_FILL;
          end
        end
        MON_FILL: begin
          if (!mon.enable) begin
            state_q <= MON_IDLE;
          end else if (fill_q == FILL_LAST) begin
            state_q <= MON_CHECK;
          end else begin
            fill_q <= fill_q + FILL_W'(1);
          end
        end
        MON_CHECK: begin
          // A constraint breach makes the comparison vacuous, so it outranks any mismatch.
          if (!mon.enable) begin
            state_q <= MON_IDLE;
          end else if (in_mis) begin
            state_q  <= MON_CONSTR;
            assume_q <= 1'b1;
          end else if (|mis_mask) begin
            state_q      <= MON_FAIL;
            violation_q  <= 1'b1;
            fail_grp_q   <= mis_mask;
            fail_cycle_q <= cycle_q;
          end else begin
            checked_q <= checked_d;
          end
        end
        MON_FAIL, MON_CONSTR: begin
          if (mon.clear) begin
            state_q      <= MON_IDLE;
            violation_q  <= 1'b0;
            assume_q     <= 1'b0;
            fail_grp_q   <= '0;
            fail_cycle_q <= '0;
          end
        end
        default: state_q <= MON_IDLE;
      endcase
    end
  end

  assign mon.violation   = violation_q;
  assign mon.assume_fail = assume_q;
  assign mon.fail_grp    = fail_grp_q;
  assign mon.fail_cycle  = fail_cycle_q;
  assign mon.checked_cnt = checked_q;
  assign mon.mon_state   = state_q;

endmodule

// File: tb/tb_dit_lockstep_monitor.sv
// Randomised bench for the lockstep monitor: two instances (skew 0 and skew 3) run
// against a cycle-indexed reference model plus directed boundary checks.
module tb_dit_lockstep_monitor;

  localparam int CTRL_W  = 64;
  localparam int NUM_GRP = 8;
  localparam int IN_W    = 8;
  localparam int OUT_W   = 2;
  localparam int CNT_W   = 32;
  localparam int GW      = CTRL_W / NUM_GRP;
  localparam int REC_W   = IN_W + CTRL_W + OUT_W;
  localparam int REC_N   = 4096;

  localparam int ST_IDLE   = 0;
  localparam int ST_FILL   = 1;
  localparam int ST_CHECK  = 2;
  localparam int ST_FAIL   = 3;
  localparam int ST_CONSTR = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  dit_lockstep_monitor_if #(.CTRL_W(CTRL_W), .NUM_GRP(NUM_GRP), .IN_W(IN_W),
                            .OUT_W(OUT_W), .CNT_W(CNT_W)) if0 ();
  dit_lockstep_monitor_if #(.CTRL_W(CTRL_W), .NUM_GRP(NUM_GRP), .IN_W(IN_W),
                            .OUT_W(OUT_W), .CNT_W(CNT_W)) if3 ();

  dit_lockstep_monitor #(.CTRL_W(CTRL_W), .NUM_GRP(NUM_GRP), .IN_W(IN_W), .OUT_W(OUT_W),
                         .SKEW(0), .CNT_W(CNT_W)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .mon     (if0)
  );

  dit_lockstep_monitor #(.CTRL_W(CTRL_W), .NUM_GRP(NUM_GRP), .IN_W(IN_W), .OUT_W(OUT_W),
                         .SKEW(3), .CNT_W(CNT_W)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .mon     (if3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: everything indexed by clock edges since reset release.
  int               m_t;
  int               m_mode [2];
  int               m_fill_left [2];
  longint unsigned  m_checked [2];
  bit               m_viol [2];
  bit               m_assume [2];
  logic [8:0]       m_grp [2];
  longint unsigned  m_fcyc [2];
  logic [REC_W-1:0] rec [2][REC_N];
  int               skew_of [2] = '{0, 3};

  // Stimulus controls.
  bit en [2];
  bit clr [2];
  int lag [2];
  bit fix_in;
  longint unsigned exp_cyc;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
      else begin
        n_bad++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic model_reset();
    m_t = 0;
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = ST_IDLE;
      m_fill_left[d] = 0;
      m_checked[d] = 0;
      m_viol[d] = 1'b0;
      m_assume[d] = 1'b0;
      m_grp[d] = '0;
      m_fcyc[d] = 0;
    end
  endtask

  // Copy A is random; copy B replays copy A from lag[d] cycles ago.
  task automatic gen(input int d);
    logic [IN_W-1:0]   ia;
    logic [CTRL_W-1:0] sa;
    logic [OUT_W-1:0]  oa;
    logic [REC_W-1:0]  b;
    ia = fix_in ? 8'h5a : 8'($urandom);
    sa = {$urandom, $urandom};
    oa = 2'($urandom);
    if (lag[d] == 0) b = {ia, sa, oa};
    else if (m_t >= lag[d]) b = rec[d][(m_t - lag[d]) % REC_N];
    else b = '0;
    if (d == 0) begin
      if0.ctrl_in_a = ia; if0.state_a = sa; if0.out_a = oa;
      {if0.ctrl_in_b, if0.state_b, if0.out_b} = b;
      if0.enable = en[0]; if0.clear = clr[0];
    end else begin
      if3.ctrl_in_a = ia; if3.state_a = sa; if3.out_a = oa;
      {if3.ctrl_in_b, if3.state_b, if3.out_b} = b;
      if3.enable = en[1]; if3.clear = clr[1];
    end
  endtask

  task automatic model(input int d);
    logic [REC_W-1:0] a_cur, a_al, bv;
    logic en_v, clr_v;
    logic [8:0] mask;
    bit in_diff;
    if (d == 0) begin
      a_cur = {if0.ctrl_in_a, if0.state_a, if0.out_a};
      bv    = {if0.ctrl_in_b, if0.state_b, if0.out_b};
      en_v = if0.enable; clr_v = if0.clear;
    end else begin
      a_cur = {if3.ctrl_in_a, if3.state_a, if3.out_a};
      bv    = {if3.ctrl_in_b, if3.state_b, if3.out_b};
      en_v = if3.enable; clr_v = if3.clear;
    end
    rec[d][m_t % REC_N] = a_cur;
    a_al = (m_t >= skew_of[d]) ? rec[d][(m_t - skew_of[d]) % REC_N] : '0;
    in_diff = (a_al[REC_W-1 -: IN_W] != bv[REC_W-1 -: IN_W]);
    mask = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      mask[g] = (a_al[OUT_W + g*GW +: GW] != bv[OUT_W + g*GW +: GW]);
    end
    mask[NUM_GRP] = (a_al[OUT_W-1:0] != bv[OUT_W-1:0]);
    case (m_mode[d])
      ST_IDLE: begin
        if (en_v) begin
          m_fill_left[d] = skew_of[d];
          m_mode[d] = (skew_of[d] == 0) ? ST_CHECK : ST_FILL;
        end
      end
      ST_FILL: begin
        if (!en_v) m_mode[d] = ST_IDLE;
        else begin
          m_fill_left[d]--;
          if (m_fill_left[d] == 0) m_mode[d] = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!en_v) m_mode[d] = ST_IDLE;
        else if (in_diff) begin
          m_mode[d] = ST_CONSTR; m_assume[d] = 1'b1;
        end else if (mask != 0) begin
          m_mode[d] = ST_FAIL; m_viol[d] = 1'b1; m_grp[d] = mask; m_fcyc[d] = longint'(m_t);
        end else m_checked[d]++;
      end
      default: begin
        if (clr_v) begin
          m_mode[d] = ST_IDLE; m_viol[d] = 1'b0; m_assume[d] = 1'b0;
          m_grp[d] = '0; m_fcyc[d] = 0;
        end
      end
    endcase
  endtask

  task automatic check_all(input int d);
    if (d == 0) begin
      chk("d0 violation", if0.violation, m_viol[0]);
      chk("d0 assume_fail", if0.assume_fail, m_assume[0]);
      chk("d0 fail_grp", if0.fail_grp, m_grp[0]);
      chk("d0 fail_cycle", if0.fail_cycle, m_fcyc[0]);
      chk("d0 checked_cnt", if0.checked_cnt, m_checked[0]);
      chk("d0 mon_state", if0.mon_state, m_mode[0]);
    end else begin
      chk("d3 violation", if3.violation, m_viol[1]);
      chk("d3 assume_fail", if3.assume_fail, m_assume[1]);
      chk("d3 fail_grp", if3.fail_grp, m_grp[1]);
      chk("d3 fail_cycle", if3.fail_cycle, m_fcyc[1]);
      chk("d3 checked_cnt", if3.checked_cnt, m_checked[1]);
      chk("d3 mon_state", if3.mon_state, m_mode[1]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      model(d);
      check_all(d);
    end
    m_t++;
  endtask

  task automatic gen_step();
    gen(0);
    gen(1);
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst d0 violation", if0.violation, 0);
    chk("rst d0 assume_fail", if0.assume_fail, 0);
    chk("rst d0 fail_grp", if0.fail_grp, 0);
    chk("rst d0 fail_cycle", if0.fail_cycle, 0);
    chk("rst d0 checked_cnt", if0.checked_cnt, 0);
    chk("rst d0 mon_state", if0.mon_state, 0);
    chk("rst d3 checked_cnt", if3.checked_cnt, 0);
    chk("rst d3 mon_state", if3.mon_state, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    en = '{0, 0}; clr = '{0, 0}; lag = '{0, 3}; fix_in = 1'b0;
    model_reset();
    gen(0); gen(1);
    #2;
    do_reset();

    // Identical streams, skew 0: 1000 compared cycles after CHECK entry.
    en[0] = 1'b1;
    repeat (1001) gen_step();
    chk("t1 checked_cnt", if0.checked_cnt, 1000);
    chk("t1 violation", if0.violation, 0);

    // Single-bit divergence in group 1.
    repeat (49) gen_step();
    gen(0); gen(1);
    if0.state_b[9] = ~if0.state_b[9];
    exp_cyc = longint'(m_t);
    step();
    chk("t2 violation", if0.violation, 1);
    chk("t2 fail_grp", if0.fail_grp, 9'h002);
    chk("t2 fail_cycle", if0.fail_cycle, exp_cyc);
    chk("t2 mon_state", if0.mon_state, ST_FAIL);
    repeat (3) gen_step();
    clr[0] = 1'b1;
    gen_step();
    clr[0] = 1'b0;
    chk("t2 clear state", if0.mon_state, ST_IDLE);
    chk("t2 clear checked", if0.checked_cnt, 1049);

    // Output-only divergence; a clear pulse in CHECK must be ignored.
    gen_step();
    repeat (2) gen_step();
    clr[0] = 1'b1;
    gen_step();
    clr[0] = 1'b0;
    repeat (2) gen_step();
    gen(0); gen(1);
    if0.out_b[0] = ~if0.out_b[0];
    step();
    chk("t3 fail_grp", if0.fail_grp, 9'h100);
    chk("t3 mon_state", if0.mon_state, ST_FAIL);
    clr[0] = 1'b1;
    gen_step();
    clr[0] = 1'b0;

    // Input breach together with a state mismatch.
    repeat (4) gen_step();
    gen(0); gen(1);
    if0.ctrl_in_b = if0.ctrl_in_b ^ 8'h01;
    if0.state_b[20] = ~if0.state_b[20];
    step();
    chk("t4 assume_fail", if0.assume_fail, 1);
    chk("t4 violation", if0.violation, 0);
    chk("t4 mon_state", if0.mon_state, ST_CONSTR);
    clr[0] = 1'b1;
    gen_step();
    clr[0] = 1'b0;

    // Dropping enable in CHECK returns to IDLE.
    repeat (3) gen_step();
    en[0] = 1'b0;
    gen_step();
    chk("t4 disable state", if0.mon_state, ST_IDLE);

    // Skew 3: FILL lasts three cycles, then clean checking.
    fix_in = 1'b1;
    en[1] = 1'b1;
    gen_step();
    chk("t5 fill 1", if3.mon_state, ST_FILL);
    gen_step();
    chk("t5 fill 2", if3.mon_state, ST_FILL);
    gen_step();
    chk("t5 fill 3", if3.mon_state, ST_FILL);
    gen_step();
    chk("t5 check entry", if3.mon_state, ST_CHECK);
    repeat (40) gen_step();
    chk("t5 checked_cnt", if3.checked_cnt, 40);
    chk("t5 violation", if3.violation, 0);
    lag[1] = 2;
    gen_step();
    chk("t5 lag2 violation", if3.violation, 1);
    chk("t5 lag2 assume", if3.assume_fail, 0);
    clr[1] = 1'b1;
    gen_step();
    clr[1] = 1'b0;
    en[1] = 1'b0;
    lag[1] = 3;
    fix_in = 1'b0;
    gen_step();

    // Reset mid-CHECK, then fail and clear with checked_cnt retained.
    en[0] = 1'b1;
    repeat (21) gen_step();
    do_reset();
    repeat (10) gen_step();
    gen(0); gen(1);
    if0.state_b[63] = ~if0.state_b[63];
    exp_cyc = longint'(m_t);
    step();
    chk("t6 fail_grp", if0.fail_grp, 9'h080);
    chk("t6 fail_cycle", if0.fail_cycle, exp_cyc);
    clr[0] = 1'b1;
    gen_step();
    clr[0] = 1'b0;
    chk("t6 clear state", if0.mon_state, ST_IDLE);
    chk("t6 clear checked", if0.checked_cnt, 9);
    chk("t6 clear fail_cycle", if0.fail_cycle, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
